// File: rtl/nibble_bus_responder.sv
// Target-side responder for the CPU's 12-bit-address / 4-bit-data bus.
// It serves a nibble RAM window, a TX FIFO toward a host, an RX FIFO from
// a host, and a status register.
// Optional cycle timer at 0xF03..0xF05 is built when BUS_RESP_TIMER_EN is defined.
module nibble_bus_responder #(
  parameter int RAM_AW  = 8,
  parameter int FIFO_AW = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] bus_addr,
  input  logic        bus_data_rw,
  input  logic [3:0]  bus_wdata,
  output logic [3:0]  bus_rdata,
  output logic [3:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [3:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int PW    = FIFO_AW + 1;

  localparam logic [11:0] ADDR_TXD  = 12'hF00;
  localparam logic [11:0] ADDR_RXD  = 12'hF01;
  localparam logic [11:0] ADDR_STAT = 12'hF02;
`ifdef BUS_RESP_TIMER_EN
  localparam logic [11:0] ADDR_TCNT = 12'hF03;
  localparam logic [11:0] ADDR_SLO  = 12'hF04;
  localparam logic [11:0] ADDR_SHI  = 12'hF05;
`endif

  logic [3:0] ram    [1 << RAM_AW];
  logic [3:0] tx_mem [DEPTH];
  logic [3:0] rx_mem [DEPTH];

  logic [PW-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
  logic [PW-1:0] tx_count;
  logic          tx_ovf, rx_unf;

  logic          prev_valid;
  logic [11:0]   prev_addr;
  logic          prev_rw;

  logic              new_access, is_ram;
  logic [RAM_AW-1:0] ram_idx;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic              cpu_tx_push, tx_push_ok, tx_pop, rx_push, cpu_rx_pop, stat_wr;
  logic [3:0]        read_data;

`ifdef BUS_RESP_TIMER_EN
  logic [11:0] timer_cnt;
  logic [7:0]  timer_snap;
  logic        timer_clear, timer_latch;
`endif

  // Address decode, FIFO flags and the strobes that move FIFO pointers.
  // Pushes and pops only fire on the first cycle of an access, because the
  // CPU holds a bus access for several cycles.
  always_comb begin
    new_access  = !prev_valid || (bus_addr != prev_addr) || (bus_data_rw != prev_rw);
    is_ram      = (bus_addr >> RAM_AW) == 12'd0;
    ram_idx     = bus_addr[RAM_AW-1:0];
    tx_empty    = tx_wr_ptr == tx_rd_ptr;
    tx_full     = (tx_wr_ptr[PW-1] != tx_rd_ptr[PW-1]) &&
                  (tx_wr_ptr[FIFO_AW-1:0] == tx_rd_ptr[FIFO_AW-1:0]);
    rx_empty    = rx_wr_ptr == rx_rd_ptr;
    rx_full     = (rx_wr_ptr[PW-1] != rx_rd_ptr[PW-1]) &&
                  (rx_wr_ptr[FIFO_AW-1:0] == rx_rd_ptr[FIFO_AW-1:0]);
    tx_count    = tx_wr_ptr - tx_rd_ptr;
    cpu_tx_push = new_access && bus_data_rw && (bus_addr == ADDR_TXD);
    tx_push_ok  = cpu_tx_push && !tx_full;
    tx_pop      = !tx_empty && tx_ready;
    rx_push     = rx_valid && !rx_full;
    cpu_rx_pop  = new_access && !bus_data_rw && (bus_addr == ADDR_RXD);
    stat_wr     = bus_data_rw && (bus_addr == ADDR_STAT);
`ifdef BUS_RESP_TIMER_EN
    timer_clear = bus_data_rw && (bus_addr == ADDR_TCNT);
    timer_latch = new_access && !bus_data_rw && (bus_addr == ADDR_TCNT);
`endif
  end

  // Read multiplexer; an empty RX FIFO reads as zero.
  always_comb begin
    read_data = 4'h0;
    if (is_ram) begin
      read_data = ram[ram_idx];
    end else begin
      case (bus_addr)
        ADDR_TXD:  read_data = {1'b0, 3'(tx_count)};
        ADDR_RXD:  read_data = rx_empty ? 4'h0 : rx_mem[rx_rd_ptr[FIFO_AW-1:0]];
        ADDR_STAT: read_data = {!rx_empty, tx_full, tx_ovf, rx_unf};
`ifdef BUS_RESP_TIMER_EN
        ADDR_TCNT: read_data = timer_cnt[3:0];
        ADDR_SLO:  read_data = timer_snap[3:0];
        ADDR_SHI:  read_data = timer_snap[7:4];
`endif
        default:   read_data = 4'h0;
      endcase
    end
  end

  assign tx_valid = !tx_empty;
  assign tx_data  = tx_mem[tx_rd_ptr[FIFO_AW-1:0]];
  assign rx_ready = !rx_full;

  // Control state: access edge detector, FIFO pointers, sticky flags and
  // read data. A held RXD read keeps the popped value instead of refreshing.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_valid <= 1'b0;
      prev_addr  <= 12'h000;
      prev_rw    <= 1'b0;
      tx_wr_ptr  <= '0;
      tx_rd_ptr  <= '0;
      rx_wr_ptr  <= '0;
      rx_rd_ptr  <= '0;
      tx_ovf     <= 1'b0;
      rx_unf     <= 1'b0;
      bus_rdata  <= 4'h0;
    end else begin
      prev_valid <= 1'b1;
      prev_addr  <= bus_addr;
      prev_rw    <= bus_data_rw;
      if (tx_push_ok) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)     tx_rd_ptr <= tx_rd_ptr + 1'b1;
      if (rx_push)    rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (cpu_rx_pop && !rx_empty) rx_rd_ptr <= rx_rd_ptr + 1'b1;
      if (cpu_tx_push && tx_full)       tx_ovf <= 1'b1;
      else if (stat_wr && bus_wdata[1]) tx_ovf <= 1'b0;
      if (cpu_rx_pop && rx_empty)       rx_unf <= 1'b1;
      else if (stat_wr && bus_wdata[0]) rx_unf <= 1'b0;
      if (!bus_data_rw && (new_access || (bus_addr != ADDR_RXD)))
        bus_rdata <= read_data;
    end
  end

  // Data storage, never reset; RAM writes repeat every write cycle harmlessly.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (bus_data_rw && is_ram) ram[ram_idx] <= bus_wdata;
      if (tx_push_ok) tx_mem[tx_wr_ptr[FIFO_AW-1:0]] <= bus_wdata;
      if (rx_push)    rx_mem[rx_wr_ptr[FIFO_AW-1:0]] <= rx_data;
    end
  end

`ifdef BUS_RESP_TIMER_EN
  // Free-running cycle counter; a new read of the low nibble snapshots the
  // upper eight bits so the CPU can assemble a coherent 12-bit value.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_cnt  <= 12'h000;
      timer_snap <= 8'h00;
    end else begin
      if (timer_clear) timer_cnt <= 12'h000;
      else             timer_cnt <= timer_cnt + 12'd1;
      if (timer_latch) timer_snap <= timer_cnt[11:4];
    end
  end
`endif

endmodule

// File: tb/tb_nibble_bus_responder.sv
// Self-checking bench for nibble_bus_responder: directed scenarios followed
// by randomized bus/host traffic, compared against a queue-based model.
module tb_nibble_bus_responder;

  logic        clk;
  logic        rst;
  logic [11:0] bus_addr;
  logic        bus_data_rw;
  logic [3:0]  bus_wdata;
  logic [3:0]  bus_rdata;
  logic [3:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [3:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [3:0] m_ram    [256];
  bit         m_ram_ok [256];
  logic [3:0] m_txq [$];
  logic [3:0] m_rxq [$];
  bit         m_ovf, m_unf;
  bit         m_pv, m_prw;
  logic [11:0] m_pa;
  logic [3:0] m_rdata;
  bit         m_rdata_ok;
`ifdef BUS_RESP_TIMER_EN
  int         m_cnt;
  int         m_snap;
`endif

  nibble_bus_responder dut (
    .clk         (clk),
    .rst         (rst),
    .bus_addr    (bus_addr),
    .bus_data_rw (bus_data_rw),
    .bus_wdata   (bus_wdata),
    .bus_rdata   (bus_rdata),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock edge of the responder, described by its bus-level rules.
  task automatic modelStep();
    bit   is_new, tx_full_pre, rx_room_pre, host_pop, cpu_push;
`ifdef BUS_RESP_TIMER_EN
    int   cnt_pre;
`endif
    if (rst) begin
      m_txq.delete();
      m_rxq.delete();
      m_ovf = 0; m_unf = 0;
      m_pv = 0; m_pa = 12'h000; m_prw = 0;
      m_rdata = 4'h0; m_rdata_ok = 1;
`ifdef BUS_RESP_TIMER_EN
      m_cnt = 0; m_snap = 0;
`endif
      return;
    end
    is_new      = !m_pv || (bus_addr != m_pa) || (bus_data_rw != m_prw);
    tx_full_pre = (m_txq.size() == 4);
    rx_room_pre = (m_rxq.size() < 4);
    host_pop    = (m_txq.size() != 0) && tx_ready;
    cpu_push    = 0;
`ifdef BUS_RESP_TIMER_EN
    cnt_pre = m_cnt;
    m_cnt   = (bus_data_rw && bus_addr == 12'hF03) ? 0 : (m_cnt + 1) % 4096;
`endif
    if (!bus_data_rw) begin
      m_rdata_ok = 1;
      if (bus_addr < 12'd256) begin
        m_rdata    = m_ram[bus_addr[7:0]];
        m_rdata_ok = m_ram_ok[bus_addr[7:0]];
      end else begin
        case (bus_addr)
          12'hF00: m_rdata = 4'(m_txq.size());
          12'hF01: begin
            if (is_new) begin
              if (m_rxq.size() == 0) begin
                m_rdata = 4'h0;
                m_unf   = 1;
              end else begin
                m_rdata = m_rxq.pop_front();
              end
            end
          end
          12'hF02: m_rdata = {m_rxq.size() != 0, tx_full_pre, m_ovf, m_unf};
`ifdef BUS_RESP_TIMER_EN
          12'hF03: begin
            m_rdata = 4'(cnt_pre % 16);
            if (is_new) m_snap = cnt_pre / 16;
          end
          12'hF04: m_rdata = 4'(m_snap % 16);
          12'hF05: m_rdata = 4'(m_snap / 16);
`endif
          default: m_rdata = 4'h0;
        endcase
      end
    end else begin
      if (bus_addr < 12'd256) begin
        m_ram[bus_addr[7:0]]    = bus_wdata;
        m_ram_ok[bus_addr[7:0]] = 1;
      end else if (bus_addr == 12'hF00 && is_new) begin
        if (tx_full_pre) m_ovf = 1;
        else             cpu_push = 1;
      end else if (bus_addr == 12'hF02) begin
        if (bus_wdata[1]) m_ovf = 0;
        if (bus_wdata[0]) m_unf = 0;
      end
    end
    if (host_pop) void'(m_txq.pop_front());
    if (cpu_push) m_txq.push_back(bus_wdata);
    if (rx_valid && rx_room_pre) m_rxq.push_back(rx_data);
    m_pv = 1; m_pa = bus_addr; m_prw = bus_data_rw;
  endtask

  // Drive one bus cycle, advance the model at the edge, then compare.
  task automatic applyStimulus(input logic [11:0] addr, input logic rw, input logic [3:0] wd);
    bus_addr    = addr;
    bus_data_rw = rw;
    bus_wdata   = wd;
    @(posedge clk);
    modelStep();
    #1;
    if (m_rdata_ok) checkOutput("bus_rdata", {8'h00, bus_rdata}, {8'h00, m_rdata});
    checkOutput("tx_valid", {11'h0, tx_valid}, {11'h0, m_txq.size() != 0});
    if (m_txq.size() != 0) checkOutput("tx_data", {8'h00, tx_data}, {8'h00, m_txq[0]});
    checkOutput("rx_ready", {11'h0, rx_ready}, {11'h0, m_rxq.size() < 4});
  endtask

  initial begin
    logic [3:0]  seen [$];
    logic [3:0]  lo, mid, hi;
    logic [11:0] addr;
    logic        rw;
    logic [3:0]  wd;
    int          hold;

    rst = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 4'h0;
    bus_addr = 12'h000; bus_data_rw = 1'b0; bus_wdata = 4'h0;
    applyStimulus(12'h3FF, 1'b0, 4'h0);
    applyStimulus(12'h3FF, 1'b0, 4'h0);
    checkOutput("reset_rdata", {8'h00, bus_rdata}, 12'h000);
    checkOutput("reset_tx_valid", {11'h0, tx_valid}, 12'h000);
    checkOutput("reset_rx_ready", {11'h0, rx_ready}, 12'h001);
    rst = 1'b0;

    // RAM write and read back, then an unmapped read
    applyStimulus(12'h012, 1'b1, 4'hA);
    applyStimulus(12'h012, 1'b1, 4'hA);
    applyStimulus(12'h012, 1'b0, 4'h0);
    checkOutput("ram_read", {8'h00, bus_rdata}, 12'h00A);
    applyStimulus(12'h3FF, 1'b0, 4'h0);
    checkOutput("unmapped_read", {8'h00, bus_rdata}, 12'h000);

    // Fill TX past full with the host stalled
    for (int v = 1; v <= 5; v++) begin
      applyStimulus(12'hF00, 1'b1, 4'(v));
      applyStimulus(12'h000, 1'b0, 4'h0);
    end
    applyStimulus(12'hF02, 1'b0, 4'h0);
    checkOutput("stat_tx_overflow", {8'h00, bus_rdata}, 12'h006);

    // Drain TX to the host
    tx_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (tx_valid) seen.push_back(tx_data);
      applyStimulus(12'h3FF, 1'b0, 4'h0);
    end
    checkOutput("tx_drain_count", 12'(seen.size()), 12'd4);
    for (int i = 0; i < 4 && i < seen.size(); i++)
      checkOutput("tx_drain_order", {8'h00, seen[i]}, 12'(i + 1));
    checkOutput("tx_drained", {11'h0, tx_valid}, 12'h000);
    applyStimulus(12'hF02, 1'b1, 4'h2);

    // RX: host pushes 7 and 8, CPU pops with held and repeated accesses
    rx_valid = 1'b1; rx_data = 4'h7;
    applyStimulus(12'h3FF, 1'b0, 4'h0);
    rx_data = 4'h8;
    applyStimulus(12'h3FF, 1'b0, 4'h0);
    rx_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(12'hF01, 1'b0, 4'h0);
      checkOutput("rx_held_pop", {8'h00, bus_rdata}, 12'h007);
    end
    applyStimulus(12'h3FF, 1'b0, 4'h0);
    applyStimulus(12'hF01, 1'b0, 4'h0);
    checkOutput("rx_second_pop", {8'h00, bus_rdata}, 12'h008);
    applyStimulus(12'h3FF, 1'b0, 4'h0);
    applyStimulus(12'hF01, 1'b0, 4'h0);
    checkOutput("rx_underflow_data", {8'h00, bus_rdata}, 12'h000);
    applyStimulus(12'hF02, 1'b0, 4'h0);
    checkOutput("stat_rx_underflow", {8'h00, bus_rdata}, 12'h001);
    applyStimulus(12'hF02, 1'b1, 4'h1);
    applyStimulus(12'hF02, 1'b0, 4'h0);
    checkOutput("stat_cleared", {8'h00, bus_rdata}, 12'h000);

    // Held write pushes exactly once
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(12'hF00, 1'b1, 4'h3);
    applyStimulus(12'hF00, 1'b0, 4'h0);
    checkOutput("held_write_count", {8'h00, bus_rdata}, 12'h001);

    // Reset in the middle of traffic
    applyStimulus(12'h3FF, 1'b0, 4'h0);
    applyStimulus(12'hF00, 1'b1, 4'h4);
    rst = 1'b1;
    applyStimulus(12'h3FF, 1'b0, 4'h0);
    checkOutput("midreset_tx_valid", {11'h0, tx_valid}, 12'h000);
    checkOutput("midreset_rdata", {8'h00, bus_rdata}, 12'h000);
    rst = 1'b0;
    applyStimulus(12'hF02, 1'b0, 4'h0);
    checkOutput("midreset_stat", {8'h00, bus_rdata}, 12'h000);
    applyStimulus(12'hF00, 1'b1, 4'h9);
    checkOutput("post_reset_push_valid", {11'h0, tx_valid}, 12'h001);
    checkOutput("post_reset_push_data", {8'h00, tx_data}, 12'h009);

    // Timer window: clear, wait, then assemble the snapshot
    applyStimulus(12'hF03, 1'b1, 4'h0);
    applyStimulus(12'hF03, 1'b1, 4'h0);
    for (int i = 0; i < 12'h123; i++) applyStimulus(12'h3FF, 1'b0, 4'h0);
    applyStimulus(12'hF03, 1'b0, 4'h0); lo  = bus_rdata;
    applyStimulus(12'hF04, 1'b0, 4'h0); mid = bus_rdata;
    applyStimulus(12'hF05, 1'b0, 4'h0); hi  = bus_rdata;
`ifdef BUS_RESP_TIMER_EN
    checkOutput("timer_snapshot", {hi, mid, lo}, 12'h123);
`else
    checkOutput("timer_absent", {hi, mid, lo}, 12'h000);
`endif

    // Randomized traffic
    for (int op = 0; op < 1500; op++) begin
      case ($urandom_range(0, 11))
        0:       addr = 12'($urandom_range(0, 15));
        1:       addr = 12'h0FF;
        2:       addr = 12'h100;
        3:       addr = 12'h3FF;
        4, 5:    addr = 12'hF00;
        6, 7:    addr = 12'hF01;
        8:       addr = 12'hF02;
        9:       addr = 12'hF03 + 12'($urandom_range(0, 2));
        10:      addr = 12'hF06;
        default: addr = 12'hFFF;
      endcase
      rw   = 1'($urandom_range(0, 1));
      wd   = 4'($urandom);
      hold = $urandom_range(1, 3);
      for (int h = 0; h < hold; h++) begin
        rst      = ($urandom_range(0, 199) == 0);
        tx_ready = ($urandom_range(0, 3) == 0);
        rx_valid = 1'($urandom_range(0, 1));
        rx_data  = 4'($urandom);
        applyStimulus(addr, rw, wd);
      end
      rst = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
